// File: rtl/burst_synch_ram.sv
// burst_synch_ram: command-decoded synchronous RAM fed by (DATA_W+2)-bit
// receive words. Supports write/read address set, writes with wrapping
// post-increment, and multi-word burst reads over a valid/ready handshake.
module burst_synch_ram #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256,
  parameter bit          AUTO_INC  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W+1:0]   din,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [DATA_W-1:0]   dout,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                err
);

  localparam int unsigned CMD_W = DATA_W + 2;

  typedef enum logic [1:0] {
    OP_WADDR  = 2'b00,
    OP_WDATA  = 2'b01,
    OP_RADDR  = 2'b10,
    OP_RBURST = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [DATA_W-1:0] payload;
  } cmd_t;

  // Storage: no reset, contents survive rst.
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              tx_valid_q, tx_valid_d;
  logic              err_q, err_d;

  cmd_t              cmd;
  logic              addr_ok;
  logic              mem_we;
  logic [DATA_W-1:0] rd_word;

  // Wrapping successor; exact for non-power-of-two depths.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(MEM_DEPTH - 1)) begin
      return '0;
    end
    return a + ADDR_W'(1);
  endfunction

  // Address step applied after each write or each read word.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a);
    if (AUTO_INC) begin
      return next_addr(a);
    end
    return a;
  endfunction

  // Split the receive word into opcode and payload.
  assign cmd = cmd_t'(din[CMD_W-1:0]);

  // Full payload compare also rejects any set bits above ADDR_W.
  assign addr_ok = (32'(cmd.payload) < MEM_DEPTH);

  assign rd_word  = mem[rd_addr_q];
  assign rx_ready = (state_q == IDLE);

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign err      = err_q;

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rem_q      <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      rem_q      <= rem_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  // Memory write port; suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[wr_addr_q] <= cmd.payload;
    end
  end

  // Command decode, burst sequencing and next-state logic.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    rem_d      = rem_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    err_d      = 1'b0;
    mem_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          unique case (cmd.op)
            OP_WADDR: begin
              if (addr_ok) begin
                wr_addr_d = cmd.payload[ADDR_W-1:0];
              end else begin
                err_d = 1'b1;
              end
            end
            OP_WDATA: begin
              mem_we    = 1'b1;
              wr_addr_d = step_addr(wr_addr_q);
            end
            OP_RADDR: begin
              if (addr_ok) begin
                rd_addr_d = cmd.payload[ADDR_W-1:0];
              end else begin
                err_d = 1'b1;
              end
            end
            OP_RBURST: begin
              dout_d     = rd_word;
              rd_addr_d  = step_addr(rd_addr_q);
              rem_d      = cmd.payload;
              tx_valid_d = 1'b1;
              state_d    = SEND;
            end
            default: ;
          endcase
        end
      end

      SEND: begin
        // Commands arriving mid-burst are dropped and flagged.
        if (rx_valid) begin
          err_d = 1'b1;
        end
        if (tx_valid_q && tx_ready) begin
          if (rem_q == '0) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            dout_d    = rd_word;
            rd_addr_d = step_addr(rd_addr_q);
            rem_d     = rem_q - DATA_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_burst_synch_ram.sv
// Directed self-checking bench for burst_synch_ram (DATA_W=8, depth 200).
module tb_burst_synch_ram;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned MEM_DEPTH = 200;

  localparam logic [1:0] OP_WADDR  = 2'b00;
  localparam logic [1:0] OP_WDATA  = 2'b01;
  localparam logic [1:0] OP_RADDR  = 2'b10;
  localparam logic [1:0] OP_RBURST = 2'b11;

  logic              clk;
  logic              rst;
  logic [DATA_W+1:0] din;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              tx_ready;
  logic              err;

  int n_cmp;
  int n_bad;

  burst_synch_ram #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH),
    .AUTO_INC (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .dout    (dout),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one command for a single edge; returns 1 time unit after it.
  task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
    din      = {op, pl};
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    din      = 10'($urandom);
    rx_valid = 1'($urandom);
    tx_ready = 1'($urandom);
    #12;
    n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    din      = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({tx_valid, err, rx_ready} !== 3'b001) begin
        n_bad++; $display("FAIL idle_after_reset cyc=%0d got tv/err/rdy=%b exp=001", i, {tx_valid, err, rx_ready});
      end
    end
  endtask

  task automatic test_basic_burst();
    tx_ready = 1'b1;
    cmd(OP_WADDR, 8'h10);
    cmd(OP_WDATA, 8'hA5);
    cmd(OP_WDATA, 8'h5A);
    cmd(OP_RADDR, 8'h10);
    cmd(OP_RBURST, 8'h01);
    n_cmp++; if ({tx_valid, dout} !== {1'b1, 8'hA5}) begin n_bad++; $display("FAIL basic_w0 got tv=%b d=%h exp tv=1 d=a5", tx_valid, dout); end
    n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL basic_busy got=%b exp=0", rx_ready); end
    tick();
    n_cmp++; if ({tx_valid, dout} !== {1'b1, 8'h5A}) begin n_bad++; $display("FAIL basic_w1 got tv=%b d=%h exp tv=1 d=5a", tx_valid, dout); end
    tick();
    n_cmp++; if ({tx_valid, rx_ready, err} !== 3'b010) begin n_bad++; $display("FAIL basic_end got tv/rdy/err=%b exp=010", {tx_valid, rx_ready, err}); end
  endtask

  task automatic test_back_pressure();
    tx_ready = 1'b0;
    cmd(OP_RADDR, 8'h10);
    cmd(OP_RBURST, 8'h01);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({tx_valid, dout} !== {1'b1, 8'hA5}) begin n_bad++; $display("FAIL bp_hold cyc=%0d got tv=%b d=%h exp tv=1 d=a5", i, tx_valid, dout); end
      tick();
    end
    tx_ready = 1'b1;
    n_cmp++; if ({tx_valid, dout} !== {1'b1, 8'hA5}) begin n_bad++; $display("FAIL bp_w0 got tv=%b d=%h exp tv=1 d=a5", tx_valid, dout); end
    tick();
    n_cmp++; if ({tx_valid, dout} !== {1'b1, 8'h5A}) begin n_bad++; $display("FAIL bp_w1 got tv=%b d=%h exp tv=1 d=5a", tx_valid, dout); end
    tick();
    n_cmp++; if ({tx_valid, rx_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_end got tv/rdy=%b exp=01", {tx_valid, rx_ready}); end
  endtask

  task automatic test_wrap();
    tx_ready = 1'b1;
    cmd(OP_WADDR, 8'd199);
    cmd(OP_WDATA, 8'h11);
    cmd(OP_WDATA, 8'h22);
    cmd(OP_RADDR, 8'd199);
    cmd(OP_RBURST, 8'h01);
    n_cmp++; if ({tx_valid, dout} !== {1'b1, 8'h11}) begin n_bad++; $display("FAIL wrap_w0 got tv=%b d=%h exp tv=1 d=11", tx_valid, dout); end
    tick();
    n_cmp++; if ({tx_valid, dout} !== {1'b1, 8'h22}) begin n_bad++; $display("FAIL wrap_w1 got tv=%b d=%h exp tv=1 d=22", tx_valid, dout); end
    tick();
    // Out-of-range address: err pulse for exactly one cycle.
    cmd(OP_WADDR, 8'd200);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL waddr_oor_err got=%b exp=1", err); end
    tick();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL waddr_oor_pulse got=%b exp=0", err); end
    cmd(OP_RADDR, 8'hFF);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL raddr_oor_err got=%b exp=1", err); end
    // wr_addr must still be 1 (wrapped past 199 -> 0 -> 1).
    cmd(OP_WDATA, 8'h33);
    cmd(OP_RADDR, 8'd1);
    cmd(OP_RBURST, 8'h00);
    n_cmp++; if ({tx_valid, dout} !== {1'b1, 8'h33}) begin n_bad++; $display("FAIL waddr_kept got tv=%b d=%h exp tv=1 d=33", tx_valid, dout); end
    tick();
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL single_word_end got=%b exp=0", tx_valid); end
  endtask

  task automatic test_dropped_cmd();
    logic [7:0] exp_w [4];
    exp_w[0] = 8'h01; exp_w[1] = 8'h02; exp_w[2] = 8'h03; exp_w[3] = 8'h04;
    tx_ready = 1'b1;
    cmd(OP_WADDR, 8'h20);
    for (int i = 0; i < 4; i++) cmd(OP_WDATA, exp_w[i]);
    cmd(OP_WDATA, 8'h55);
    cmd(OP_RADDR, 8'h20);
    tx_ready = 1'b0;
    cmd(OP_RBURST, 8'h03);
    cmd(OP_WDATA, 8'hFF);
    n_cmp++; if ({err, tx_valid, dout} !== {1'b1, 1'b1, 8'h01}) begin n_bad++; $display("FAIL drop_err got err=%b tv=%b d=%h exp err=1 tv=1 d=01", err, tx_valid, dout); end
    tick();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL drop_pulse got=%b exp=0", err); end
    tx_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      n_cmp++; if ({tx_valid, dout} !== {1'b1, exp_w[i]}) begin n_bad++; $display("FAIL drop_w%0d got tv=%b d=%h exp tv=1 d=%h", i, tx_valid, dout, exp_w[i]); end
    end
    tick();
    n_cmp++; if ({tx_valid, rx_ready} !== 2'b01) begin n_bad++; $display("FAIL drop_end got tv/rdy=%b exp=01", {tx_valid, rx_ready}); end
    // rd_addr now points past the burst (0x24); dropped write must not have hit it.
    cmd(OP_RBURST, 8'h00);
    n_cmp++; if ({tx_valid, dout} !== {1'b1, 8'h55}) begin n_bad++; $display("FAIL drop_mem_intact got tv=%b d=%h exp tv=1 d=55", tx_valid, dout); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    tx_ready = 1'b1;
    cmd(OP_RADDR, 8'h20);
    cmd(OP_RBURST, 8'h03);
    n_cmp++; if (dout !== 8'h01) begin n_bad++; $display("FAIL rstmb_w0 got=%h exp=01", dout); end
    tick();
    n_cmp++; if (dout !== 8'h02) begin n_bad++; $display("FAIL rstmb_w1 got=%h exp=02", dout); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({tx_valid, rx_ready, dout} !== {1'b0, 1'b1, 8'h00}) begin n_bad++; $display("FAIL rstmb_async got tv=%b rdy=%b d=%h exp tv=0 rdy=1 d=00", tx_valid, rx_ready, dout); end
    tick();
    rst = 1'b0;
    // rd_addr back to 0 -> mem[0] written earlier as 0x22.
    cmd(OP_RBURST, 8'h00);
    n_cmp++; if ({tx_valid, dout} !== {1'b1, 8'h22}) begin n_bad++; $display("FAIL rstmb_rdaddr0 got tv=%b d=%h exp tv=1 d=22", tx_valid, dout); end
    tick();
    cmd(OP_RADDR, 8'h10);
    cmd(OP_RBURST, 8'h01);
    n_cmp++; if (dout !== 8'hA5) begin n_bad++; $display("FAIL rstmb_mem0 got=%h exp=a5", dout); end
    tick();
    n_cmp++; if (dout !== 8'h5A) begin n_bad++; $display("FAIL rstmb_mem1 got=%h exp=5a", dout); end
    tick();
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    din      = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    test_reset();
    test_basic_burst();
    test_back_pressure();
    test_wrap();
    test_dropped_cmd();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/burst_synch_ram.md
# burst_synch_ram

Parametrised command-decoded synchronous RAM. It sits behind the SPI slave and consumes its (DATA_W+2)-bit receive words. Adds wrapping address auto-increment, multi-word burst reads with a tx_valid/tx_ready handshake, an rx_ready back-pressure signal, and an error pulse for dropped or illegal commands.

## Interface
- DATA_W, 8, data word width; the command word is DATA_W+2 bits.
- ADDR_W, 8, address width; must be ≤ DATA_W.
- MEM_DEPTH, 256, number of words; must be ≤ 2**ADDR_W (non-power-of-two allowed).
- AUTO_INC, 1, 1 = post-increment wr_addr per write and rd_addr per read word; 0 = addresses held.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  DATA_W+2  command word: din[DATA_W+1:DATA_W] = opcode, din[DATA_W-1:0] = payload.
- rx_valid  in  1  din valid this cycle.
- rx_ready  out  1  block accepts commands; combinational, = (state==IDLE).
- dout  out  DATA_W  read data word.
- tx_valid  out  1  dout valid; held until accepted.
- tx_ready  in  1  consumer accepts dout when tx_valid & tx_ready at an edge.
- err  out  1  one-cycle pulse: command dropped or address out of range.

## Operation
- Command accepted when rx_valid & rx_ready at an edge. Opcodes:
  - 00 WADDR: wr_addr <= payload[ADDR_W-1:0].
  - 01 WDATA: mem[wr_addr] <= payload; if AUTO_INC, wr_addr <= next(wr_addr).
  - 10 RADDR: rd_addr <= payload[ADDR_W-1:0].
  - 11 RBURST: start a burst of N = payload+1 words (1..2**DATA_W).
- next(a) = (a == MEM_DEPTH-1) ? 0 : a+1. Wrap is exact for non-power-of-two depth.
- WADDR/RADDR with payload ≥ MEM_DEPTH or any nonzero payload bits above ADDR_W: address unchanged, err=1 for one cycle.
- rx_valid while rx_ready=0 (burst in progress): command dropped, no state change, err=1 for one cycle.
- State machine has two states:
  - IDLE: accepts commands. RBURST → dout <= mem[rd_addr]; rd_addr <= next(rd_addr) if AUTO_INC; rem <= payload; tx_valid <= 1; go to SEND.
  - SEND: on tx_valid & tx_ready:
    - rem==0 → tx_valid <= 0, go to IDLE.
    - else → dout <= mem[rd_addr]; rd_addr advances as above; rem <= rem-1; tx_valid stays 1.
  - Without handshake: dout and tx_valid hold.
- AUTO_INC=0: a burst returns the same word N times.
- After a burst, rd_addr points to the word following the last one sent (AUTO_INC=1).
- Memory has no reset; contents survive rst.

## Timing
- Reset (async, immediate): dout=0, tx_valid=0, err=0, wr_addr=0, rd_addr=0, rem=0, state=IDLE, so rx_ready=1.
- Write latency: a word written at edge T is readable by an RBURST accepted at edge T+1 or later.
- Read latency: RBURST accepted at edge T → tx_valid=1 with the first word after T.
- Throughput: with tx_ready held high, one word per cycle. The burst of N words occupies N cycles of tx_valid.
- rx_ready returns to 1 in the cycle after the final handshake. A command may be accepted on that cycle.
- err is registered and asserts in the cycle after the offending edge.
- rst asserted mid-burst: tx_valid drops immediately and the remaining words are abandoned.

## Test plan
- Reset: assert rst with random inputs → dout=0, tx_valid=0, err=0, rx_ready=1. Release → idle, no activity.
- Basic burst: WADDR 0x10, WDATA 0xA5, WDATA 0x5A, RADDR 0x10, RBURST payload 1 with tx_ready=1.
  - Expect dout 0xA5 then 0x5A on consecutive cycles with tx_valid=1, then tx_valid=0 and rx_ready=1.
- Back-pressure: same burst with tx_ready=0 for 3 cycles after tx_valid rises → dout=0xA5 and tx_valid held steady. Then 0xA5, 0x5A are delivered in order once tx_ready=1.
- Wrap, with MEM_DEPTH=200:
  - WADDR 199, WDATA 0x11, WDATA 0x22 → mem[199]=0x11, mem[0]=0x22.
  - RADDR 199, RBURST payload 1 → 0x11, 0x22.
  - WADDR 200 → err pulse, wr_addr unchanged.
- Dropped command: during a 4-word burst with tx_ready=0, drive WDATA 0xFF → err pulse, memory and addresses unchanged. The burst completes with the original data.
- Async reset mid-burst: assert rst after the second of 4 words → tx_valid=0 within the same cycle. After release, rd_addr=0, and previously written memory reads back intact.
